// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// pwm_pkg : shared widths, pin-field indices and compare helper for pwm_gen_top
// Rev 1.0
// ============================================================================
package pwm_pkg;

  localparam int PWM_WIDTH      = 8;
  localparam int PWM_PERIOD_MAX = 254;
  localparam int PRESC_BITS     = 3;

  // uo_out bit positions
  localparam int PWM_BIT  = 0;
  localparam int PWMN_BIT = 1;
  localparam int TICK_BIT = 2;

  // uio_in field positions
  localparam int PRESC_LSB = 0;
  localparam int INV_BIT   = 3;

  // Polarity-adjusted compare: high while the period count is below duty.
  function automatic logic pwm_level(input logic [PWM_WIDTH-1:0] cnt,
                                     input logic [PWM_WIDTH-1:0] duty,
                                     input logic                 inv);
    return (cnt < duty) ^ inv;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_deadtime.sv
`default_nettype none
// ============================================================================
// pwm_deadtime : high/low-side split of a PWM level with dead-time insertion.
// Built only with PWM_DEADTIME_EN.  Rev 1.0
// ============================================================================
module pwm_deadtime #(
  parameter int DEAD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic pwm_in,
  output logic hi,
  output logic lo
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  // The edge cycle itself is the first dead cycle, so the counter covers the rest.
  localparam logic [DW-1:0] DT_LOAD = DW'(DEAD_CYCLES - 1);

  logic          prev;
  logic [DW-1:0] dt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= 1'b0;
      dt_cnt <= '0;
      hi     <= 1'b0;
      lo     <= 1'b0;
    end else begin
      prev <= pwm_in;
      if (pwm_in != prev) begin
        dt_cnt <= DT_LOAD;
        hi     <= 1'b0;
        lo     <= 1'b0;
      end else if (dt_cnt != '0) begin
        dt_cnt <= dt_cnt - 1'b1;
        hi     <= 1'b0;
        lo     <= 1'b0;
      end else begin
        hi <= en & pwm_in;
        lo <= en & ~pwm_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_gen_top.sv
`default_nettype none
// ============================================================================
// pwm_gen_top : single-channel PWM with 2^N prescaler, polarity and shadowed duty.
// Optional PWM_DEADTIME_EN: uo_out[1:0] become a dead-timed high/low pair.  Rev 1.0
// ============================================================================
module pwm_gen_top #(
  parameter int WIDTH      = pwm_pkg::PWM_WIDTH,
  parameter int PRESC_BITS = pwm_pkg::PRESC_BITS
`ifdef PWM_DEADTIME_EN
  ,
  parameter int DEAD_CYCLES = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [7:0]       uio_in,
  output logic [7:0]       uo_out,
  output logic [7:0]       uio_out,
  output logic [7:0]       uio_oe
);

  import pwm_pkg::*;

  localparam int               PCW        = (1 << PRESC_BITS) - 1;
  localparam logic [PCW-1:0]   PRESC_ONES = '1;
  localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(PWM_PERIOD_MAX);

  logic [PRESC_BITS-1:0] presc_n;
  logic                  inv;
  logic                  unused_cfg;
  logic [PCW-1:0]        presc_cnt;
  logic [PCW-1:0]        presc_lim;
  logic                  tick_en;
  logic                  wrap;
  logic                  level;
  logic [WIDTH-1:0]      cnt;
  logic [WIDTH-1:0]      duty_q;
  logic                  tick_q;
  logic                  pwm_o;
  logic                  pwm_n_o;

  assign presc_n    = uio_in[PRESC_LSB +: PRESC_BITS];
  assign inv        = uio_in[INV_BIT];
  assign unused_cfg = ^uio_in[7:INV_BIT+1];

  // Low N bits set: terminal count 2^N - 1 without an arithmetic subtract.
  assign presc_lim = ~(PRESC_ONES << presc_n);
  assign tick_en   = ena && (presc_cnt == presc_lim);
  assign wrap      = tick_en && (cnt == CNT_MAX);
  assign level     = pwm_level(cnt, duty_q, inv);

  // >= rather than == so a live drop of N below the current count recovers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (ena) begin
      if (presc_cnt >= presc_lim) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      duty_q <= '0;
    end else if (tick_en) begin
      if (cnt == CNT_MAX) begin
        cnt    <= '0;
        duty_q <= ui_in;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
    end
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadtime #(
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_deadtime (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena),
    .pwm_in (level),
    .hi     (pwm_o),
    .lo     (pwm_n_o)
  );
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_o   <= 1'b0;
      pwm_n_o <= 1'b0;
    end else if (!ena) begin
      pwm_o   <= 1'b0;
      pwm_n_o <= 1'b0;
    end else begin
      pwm_o   <= level;
      pwm_n_o <= ~level;
    end
  end
`endif

  always_comb begin
    uo_out           = '0;
    uo_out[PWM_BIT]  = pwm_o;
    uo_out[PWMN_BIT] = pwm_n_o;
    uo_out[TICK_BIT] = tick_q;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule
`default_nettype wire

// File: tb/tb_pwm_gen_top.sv
`default_nettype none
// ============================================================================
// tb_pwm_gen_top : randomized self-checking bench; expectations from period math.
// Rev 1.0
// ============================================================================
module tb_pwm_gen_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int errors = 0;
  int checks = 0;

  pwm_gen_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (uo_out[2]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Window = cycle after a tick through the next tick inclusive: one full period.
  task automatic measure_period(input int limit, input int chg_at, input logic [7:0] chg_val,
                                output int hi, output int len, output int nbad, output bit ok);
    hi = 0; len = 0; nbad = 0; ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      len++;
      if (len == chg_at) ui_in = chg_val;
      if (uo_out[0]) hi++;
      if (uo_out[1] !== ~uo_out[0]) nbad++;
      if (uo_out[2]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int  hi, len;
    bit  seen;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h80;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reset uo_out: got %h want 00", uo_out); end
    checks++;
    if (uio_oe !== 8'h00) begin errors++; $display("FAIL reset uio_oe: got %h want 00", uio_oe); end
    checks++;
    if (uio_out !== 8'h00) begin errors++; $display("FAIL reset uio_out: got %h want 00", uio_out); end
    rst_n = 1'b1;
`ifndef PWM_DEADTIME_EN
    hi = 0; len = 0; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      len++;
      if (uo_out[0]) hi++;
      if (uo_out[2]) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || len != 255) begin errors++; $display("FAIL reset first tick: got len %0d seen %0d want 255", len, seen); end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL reset first period high: got %0d want 0", hi); end
`endif
  endtask

  task automatic test_duty50();
    int hi, len, nbad;
    bit ok;
    for (int p = 0; p < 2; p++) begin
      measure_period(400, 0, 8'h00, hi, len, nbad, ok);
      checks++;
      if (!ok || hi != 128 || len != 255 || nbad != 0) begin
        errors++;
        $display("FAIL duty50 period%0d: got hi %0d len %0d nbad %0d ok %0d want 128/255/0/1", p, hi, len, nbad, ok);
      end
    end
  endtask

  task automatic test_extremes();
    int hi, len, nbad;
    bit ok;
    logic [7:0] vals [2];
    vals[0] = 8'd0;
    vals[1] = 8'd255;
    for (int v = 0; v < 2; v++) begin
      ui_in = vals[v];
      measure_period(400, 0, 8'h00, hi, len, nbad, ok);
      for (int p = 0; p < 3; p++) begin
        measure_period(400, 0, 8'h00, hi, len, nbad, ok);
        checks++;
        if (!ok || len != 255 || hi != (vals[v] == 8'd0 ? 0 : 255) || nbad != 0) begin
          errors++;
          $display("FAIL extreme duty %0d period%0d: got hi %0d len %0d nbad %0d want hi %0d len 255",
                   vals[v], p, hi, len, nbad, (vals[v] == 8'd0 ? 0 : 255));
        end
      end
    end
  endtask

  task automatic test_prescaler();
    int hi, len, nbad;
    bit ok;
    uio_in = 8'h03;
    ui_in  = 8'd64;
    wait_tick(2600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL presc sync: no tick within 2600 clks"); end
    measure_period(2600, 0, 8'h00, hi, len, nbad, ok);
    checks++;
    if (!ok || hi != 512 || len != 2040 || nbad != 0) begin
      errors++;
      $display("FAIL presc period: got hi %0d len %0d nbad %0d want 512/2040/0", hi, len, nbad);
    end
    @(negedge clk);
    checks++;
    if (uo_out[2] !== 1'b0) begin errors++; $display("FAIL presc tick width: got tick %b after 1 clk want 0", uo_out[2]); end
    uio_in = 8'h00;
    wait_tick(2600, ok);
  endtask

  task automatic test_shadow();
    int hi, len, nbad;
    bit ok;
    ui_in = 8'd64;
    measure_period(400, 0, 8'h00, hi, len, nbad, ok);
    measure_period(400, 100, 8'd200, hi, len, nbad, ok);
    checks++;
    if (hi != 64 || len != 255) begin errors++; $display("FAIL shadow current: got hi %0d len %0d want 64/255", hi, len); end
    measure_period(400, 0, 8'h00, hi, len, nbad, ok);
    checks++;
    if (hi != 200 || len != 255) begin errors++; $display("FAIL shadow next: got hi %0d len %0d want 200/255", hi, len); end
  endtask

  task automatic test_polarity();
    int hi, len, nbad;
    bit ok;
    logic p0;
    repeat (30) @(negedge clk);
    p0 = uo_out[0];
    checks++;
    if (p0 !== 1'b1) begin errors++; $display("FAIL polarity pre: got pwm %b want 1", p0); end
    uio_in[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (uo_out[1:0] !== 2'b10) begin errors++; $display("FAIL polarity flip: got %b want 10", uo_out[1:0]); end
    wait_tick(400, ok);
    measure_period(400, 0, 8'h00, hi, len, nbad, ok);
    checks++;
    if (hi != 55 || len != 255 || nbad != 0) begin
      errors++;
      $display("FAIL polarity period: got hi %0d len %0d nbad %0d want 55/255/0", hi, len, nbad);
    end
    uio_in[3] = 1'b0;
    wait_tick(400, ok);
  endtask

  task automatic test_ena();
    int hi_pre, gap_bad, hi, len, nbad;
    bit ok;
    ui_in = 8'd100;
    measure_period(400, 0, 8'h00, hi, len, nbad, ok);
    hi_pre = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uo_out[0]) hi_pre++;
    end
    ena = 1'b0;
    gap_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uo_out[2:0] !== 3'b000) gap_bad++;
    end
    ena = 1'b1;
    measure_period(400, 0, 8'h00, hi, len, nbad, ok);
    checks++;
    if (gap_bad != 0) begin errors++; $display("FAIL ena gap: got %0d nonzero cycles want 0", gap_bad); end
    checks++;
    if (hi != 100 - hi_pre || hi_pre != 20 || len != 235 || nbad != 0) begin
      errors++;
      $display("FAIL ena resume: got pre %0d rest %0d len %0d nbad %0d want 20/80/235/0", hi_pre, hi, len, nbad);
    end
  endtask

  task automatic test_random();
    int hi, len, nbad, n, d;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(0, 2);
      d = $urandom_range(0, 255);
      uio_in = 8'(n);
      ui_in  = 8'(d);
      wait_tick(1200, ok);
      measure_period(1200, 0, 8'h00, hi, len, nbad, ok);
      checks++;
      if (!ok || hi != (d << n) || len != (255 << n) || nbad != 0) begin
        errors++;
        $display("FAIL random N=%0d D=%0d: got hi %0d len %0d nbad %0d want hi %0d len %0d",
                 n, d, hi, len, nbad, d << n, 255 << n);
      end
    end
    uio_in = 8'h00;
    wait_tick(1200, ok);
  endtask

  task automatic test_async_reset();
    int hi, len, nbad;
    bit ok, seen;
    ui_in = 8'd200;
    measure_period(400, 0, 8'h00, hi, len, nbad, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (uo_out[0] !== 1'b1) begin errors++; $display("FAIL async pre: got pwm %b want 1", uo_out[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL async clear: got %h want 00", uo_out); end
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0; len = 0; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      len++;
      if (uo_out[0]) hi++;
      if (uo_out[2]) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || hi != 0 || len != 255) begin
      errors++;
      $display("FAIL async first period: got hi %0d len %0d seen %0d want 0/255/1", hi, len, seen);
    end
    measure_period(400, 0, 8'h00, hi, len, nbad, ok);
    checks++;
    if (hi != 200 || len != 255) begin errors++; $display("FAIL async reload: got hi %0d len %0d want 200/255", hi, len); end
  endtask

  task automatic test_deadtime();
    int  run, both, gaps;
    bit  ok, active;
    ui_in = 8'd100;
    wait_tick(400, ok);
    wait_tick(400, ok);
    run = 0; both = 0; gaps = 0; active = 1'b0;
    for (int i = 0; i < 3 * 255; i++) begin
      @(negedge clk);
      if (uo_out[0] && uo_out[1]) both++;
      if (!uo_out[0] && !uo_out[1]) begin
        run++;
      end else begin
        if (active && run > 0) begin
          gaps++;
          checks++;
          if (run != 4) begin errors++; $display("FAIL deadtime gap%0d: got %0d clks want 4", gaps, run); end
        end
        run = 0;
        active = 1'b1;
      end
    end
    checks++;
    if (both != 0) begin errors++; $display("FAIL deadtime overlap: got %0d cycles want 0", both); end
    checks++;
    if (gaps < 5) begin errors++; $display("FAIL deadtime transitions: got %0d want >=5", gaps); end
  endtask

  initial begin
    test_reset();
`ifdef PWM_DEADTIME_EN
    test_deadtime();
`else
    test_duty50();
    test_extremes();
    test_prescaler();
    test_shadow();
    test_polarity();
    test_ena();
    test_random();
    test_async_reset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
